expand_to_8bit: RTL and testbench

EXPAND_TO_8BIT -- requirements
Module: expand_to_8bit

---
 rtl/expand_pkg.sv | 15 +
 rtl/bit_to_byte.sv | 15 +
 rtl/expand_to_8bit.sv | 62 ++++++
 tb/tb_expand_to_8bit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/expand_pkg.sv
// Shared constants for the bit-plane to byte-plane expander.
// No ports; imported by expand_to_8bit and bit_to_byte.
package expand_pkg;

    localparam int WORD_W     = 32;
    localparam int NUM_WORDS  = 32;
    localparam int SLICE_W    = 128;
    localparam int NUM_SLICES = 8;
    localparam int BYTE_W     = 8;
    localparam int ADDR_W     = 3;

    localparam int DATA_W     = WORD_W * NUM_WORDS;
    localparam int OUT_W      = SLICE_W * BYTE_W;

endpackage

// File: rtl/bit_to_byte.sv
// Maps one pixel bit to a full byte: ONE_VAL for 1, ZERO_VAL for 0.
// Ports: bit_i (1-bit pixel), byte_o (BYTE_W-bit expanded value).
module bit_to_byte
    import expand_pkg::*;
#(
    parameter logic [BYTE_W-1:0] ONE_VAL  = 8'h01,
    parameter logic [BYTE_W-1:0] ZERO_VAL = 8'h00
) (
    input  logic              bit_i,
    output logic [BYTE_W-1:0] byte_o
);

    assign byte_o = bit_i ? ONE_VAL : ZERO_VAL;

endmodule

// File: rtl/expand_to_8bit.sv
// Selects a 128-bit slice of a 32x32 bit-plane and expands each bit to a byte.
// Ports: clk, rst (async high), data_in/addr/in_valid in; data_out/out_valid out.
module expand_to_8bit
    import expand_pkg::*;
#(
    parameter logic [BYTE_W-1:0] ONE_VAL  = 8'h01,
    parameter logic [BYTE_W-1:0] ZERO_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              in_valid,
    output logic [OUT_W-1:0]  data_out,
    output logic              out_valid
);

    // Viewing data_in as an array of slices turns the select into a plain mux.
    logic [NUM_SLICES-1:0][SLICE_W-1:0] slices;
    logic [SLICE_W-1:0]                 slice_sel;
    logic [OUT_W-1:0]                   mapped;

    logic [OUT_W-1:0] data_d;
    logic [OUT_W-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    assign slices    = data_in;
    assign slice_sel = slices[addr];

    for (genvar i = 0; i < SLICE_W; i++) begin : g_map
        bit_to_byte #(
            .ONE_VAL  (ONE_VAL),
            .ZERO_VAL (ZERO_VAL)
        ) u_b2b (
            .bit_i  (slice_sel[i]),
            .byte_o (mapped[i*BYTE_W +: BYTE_W])
        );
    end

    always_comb begin
        data_d  = data_q;
        valid_d = in_valid;
        if (in_valid) begin
            data_d = mapped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= {SLICE_W{ZERO_VAL}};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_expand_to_8bit.sv
// Scoreboard bench for expand_to_8bit.
// Drives stimulus at posedge+1, checks outputs one cycle later.
module tb_expand_to_8bit;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] data_in;
    logic [2:0]    addr;
    logic          in_valid;
    logic [1023:0] data_out;
    logic          out_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          v;
        logic [1023:0] d;
    } exp_t;

    exp_t          sb[$];
    logic [1023:0] model_q;
    logic [1023:0] pat;

    always #5 clk = ~clk;

    expand_to_8bit #(
        .ONE_VAL  (8'h01),
        .ZERO_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .addr      (addr),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    function automatic logic [1023:0] expand(input logic [1023:0] d,
                                             input logic [2:0] a);
        logic [1023:0] r;
        int base;
        r = '0;
        base = 128 * int'(a);
        for (int i = 0; i < 128; i++)
            r[8*i +: 8] = d[base + i] ? 8'h01 : 8'h00;
        return r;
    endfunction

    // Apply one cycle of stimulus and record what the output must be after it.
    task automatic drive(input logic v, input logic [1023:0] d,
                         input logic [2:0] a);
        exp_t e;
        in_valid = v;
        data_in  = d;
        addr     = a;
        if (v) model_q = expand(d, a);
        e.v = v;
        e.d = model_q;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        addr     = '0;
        model_q  = '0;
        #2;
        checks++;
        if (data_out !== 1024'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", data_out);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_pattern;
        exp_t e;
        logic [7:0] want [12];
        logic [7:0] got;
        int idx [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
        want[0]  = 8'h00; want[1]  = 8'h01;
        want[2]  = 8'h00; want[3]  = 8'h01;
        want[8]  = 8'h01; want[9]  = 8'h01;
        want[10] = 8'h00; want[11] = 8'h00;
        drive(1'b1, pat, 3'd0);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.d) begin
            errors++;
            $display("FAIL pattern_data: got %h want %h", data_out, e.d);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pattern_valid: got %b want 1", out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            got = data_out[8*idx[k] +: 8];
            checks++;
            if (got !== want[idx[k]]) begin
                errors++;
                $display("FAIL pattern_byte%0d: got %h want %h",
                         idx[k], got, want[idx[k]]);
            end
        end
    endtask

    task automatic test_addr_indep;
        exp_t e;
        logic [2:0] al [3] = '{3'd4, 3'd5, 3'd7};
        logic [1023:0] ref_d;
        ref_d = expand(pat, 3'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, pat, al[k]);
            e = sb.pop_front();
            checks++;
            if (data_out !== e.d || data_out !== ref_d) begin
                errors++;
                $display("FAIL addr_indep_a%0d: got %h want %h",
                         al[k], data_out, ref_d);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL addr_indep_valid_a%0d: got %b want 1",
                         al[k], out_valid);
            end
        end
    endtask

    task automatic test_isolation;
        exp_t e;
        logic [1023:0] d;
        d = '0;
        d[1023] = 1'b1;
        drive(1'b1, d, 3'd7);
        e = sb.pop_front();
        checks++;
        if (data_out[1023:1016] !== 8'h01) begin
            errors++;
            $display("FAIL iso_byte127: got %h want 01", data_out[1023:1016]);
        end
        checks++;
        if (data_out[1015:0] !== '0 || data_out !== e.d) begin
            errors++;
            $display("FAIL iso_others: got %h want %h", data_out, e.d);
        end
        drive(1'b1, d, 3'd6);
        e = sb.pop_front();
        checks++;
        if (data_out !== 1024'h0 || data_out !== e.d) begin
            errors++;
            $display("FAIL iso_addr6: got %h want 0", data_out);
        end
    endtask

    task automatic test_hold;
        exp_t e;
        drive(1'b1, pat, 3'd2);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.d) begin
            errors++;
            $display("FAIL hold_load: got %h want %h", data_out, e.d);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, (k % 2 == 0) ? ~pat : {32{32'hDEADBEEF}},
                  3'(k + 1));
            e = sb.pop_front();
            checks++;
            if (data_out !== e.d) begin
                errors++;
                $display("FAIL hold_data%0d: got %h want %h",
                         k, data_out, e.d);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_valid%0d: got %b want 0", k, out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        logic [1023:0] d2;
        d2 = {32{32'h0F0F_1234}};
        drive(1'b1, pat, 3'd1);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.d) begin
            errors++;
            $display("FAIL mid_pre: got %h want %h", data_out, e.d);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 1024'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got %h/%b want 0/0", data_out, out_valid);
        end
        in_valid = 1'b1;
        data_in  = d2;
        addr     = 3'd3;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 1024'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_priority: got %h/%b want 0/0",
                     data_out, out_valid);
        end
        rst     = 1'b0;
        model_q = '0;
        drive(1'b1, d2, 3'd3);
        e = sb.pop_front();
        checks++;
        if (data_out !== e.d || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_post: got %h/%b want %h/1",
                     data_out, out_valid, e.d);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [1023:0] d;
        logic v;
        for (int n = 0; n < 40; n++) begin
            for (int w = 0; w < 32; w++) d[32*w +: 32] = $urandom;
            v = (n < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            drive(v, d, 3'($urandom_range(0, 7)));
            e = sb.pop_front();
            checks++;
            if (data_out !== e.d || out_valid !== e.v) begin
                errors++;
                $display("FAIL b2b_%0d: got %h/%b want %h/%b",
                         n, data_out, out_valid, e.d, e.v);
            end
        end
    endtask

    initial begin
        pat = {64{16'h33AA}};
        test_reset();
        test_pattern();
        test_addr_indep();
        test_isolation();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
